jk_bank_controller: RTL
=======================

Name: jk_bank_controller

Overview:
Command-driven sequencer for a bank of WIDTH JK flip-flops. It accepts one command at a time over a valid/ready handshake. It translates each command into per-bit J/K patterns: clear, set, toggle, load, or count up/down for a programmed number of cycles. It raises a one-cycle completion pulse when the command finishes. It sits between a host/test controller and the flip-flop bank and is the only driver of the bank's J/K inputs.

Parameters:
WIDTH, 4, number of JK flip-flops in the bank (1..16)
CNT_W, 8, width of the count-length field

Ports:
Clk  input  1  system clock; all state changes on rising edge
Reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising Clk)
Cmd_valid  input  1  host presents a command
Cmd_ready  output  1  controller can accept a command (high only in IDLE)
Cmd_op  input  3  opcode: 0 NOP, 1 CLEAR, 2 SET, 3 TOGGLE, 4 LOAD, 5 COUNT_UP, 6 COUNT_DOWN, 7 reserved
Cmd_data  input  WIDTH  bit mask for CLEAR/SET/TOGGLE; load value for LOAD; ignored otherwise
Cmd_len  input  CNT_W  number of count cycles for COUNT_UP/DOWN; ignored otherwise
Q  output  WIDTH  flip-flop bank state
J_bus  output  WIDTH  J inputs currently applied to the bank
K_bus  output  WIDTH  K inputs currently applied to the bank
Busy  output  1  command in progress (state != IDLE)
Done  output  1  one-cycle pulse on command completion

Behaviour:
- Reset (Reset==0 at a rising edge):
  - Q=0, state=IDLE, Done=0, internal op/data/len registers cleared.
  - Reset overrides any in-progress command: abort, no Done pulse.
- After reset: Cmd_ready=1, Busy=0, J_bus=K_bus=0.
- FSM states: IDLE, APPLY, COUNT, DONE.
- IDLE:
  - J_bus=K_bus=0, so the bank holds.
  - Cmd_ready=1.
  - On Cmd_valid&&Cmd_ready at an edge, latch op/data/len.
  - Next state: ops 1-4 go to APPLY; ops 5/6 go to COUNT if len!=0, else DONE; ops 0/7 go to DONE.
- APPLY (exactly one cycle), then go to DONE:
  - CLEAR: J=0, K=mask.
  - SET: J=mask, K=0.
  - TOGGLE: J=K=mask.
  - LOAD: J=data, K=~data.
- COUNT:
  - Per-bit toggle enable t[0]=1; t[i]=&Q[i-1:0] for UP, t[i]=&(~Q[i-1:0]) for DOWN. J_bus=K_bus=t.
  - Remaining-count register is loaded with len and decremented each COUNT cycle. Leave for DONE after the cycle in which it equals 1.
  - Wrap-around is natural modulo 2^WIDTH (UP from all-ones gives 0; DOWN from 0 gives all-ones).
- DONE (one cycle): Done=1, Cmd_ready=0, Busy=1, J/K=0. Next state is IDLE.
- Latency from accept edge t:
  - Ops 1-4: Q updates at edge t+1, Done high in cycle t+1..t+2, Cmd_ready high again from edge t+2.
  - COUNT of length L: Q updates at edges t+1..t+L, Done in the cycle after edge t+L.
  - NOP, reserved, or L=0: Done in the cycle after edge t, Q unchanged.
- Cmd_valid while not ready: ignored. Host must hold the command until the handshake; no queueing.
- Cmd_ready is combinational from state only, never from Cmd_valid.
- Bits outside the mask are held (J=K=0) in CLEAR/SET/TOGGLE.
- Q is the output of the flip-flop bank itself, never a shadow copy.

Decomposition:
- Shared package: opcode constants (OP_NOP..OP_COUNT_DN) and FSM state encodings (2-bit).
- One natural sub-module: jk_cell, a single JK flip-flop with Clk, synchronous active-low Reset, J, K, Q, Q_bar. Behaviour: 00 hold, 01 reset, 10 set, 11 toggle. Instantiate it WIDTH times via generate.
- Controller FSM, count register and J/K decode live in jk_bank_controller.

Test Plan:
1. Reset low for 2 edges, then high -> Q=0000, Cmd_ready=1, Busy=0, Done=0, J_bus=K_bus=0.
2. LOAD data=1010, then TOGGLE mask=0011 -> Q=1010 after first Done, Q=1001 after second. Each Done is exactly one cycle wide, and Cmd_ready is low for exactly 2 cycles per command.
3. SET mask=0101 from Q=1000, then CLEAR mask=1100 -> Q=1101, then Q=0001. Unmasked bits unchanged.
4. LOAD 1110, then COUNT_UP len=3 -> Q sequence 1111, 0000, 0001 (wrap). Done asserted one cycle after the third update. Then COUNT_DOWN len=2 -> 0000, 1111.
5. COUNT_UP len=0 and op=7 -> Done in the cycle after accept, Q unchanged. Cmd_valid held high during Busy produces no extra accepts (count handshakes = commands issued).
6. COUNT_UP len=200 from 0000, Reset pulled low at cycle 10 -> Q=0000 at next edge, no Done pulse, Cmd_ready=1 after release. A following LOAD 0110 completes normally.

Source files
------------

// File: rtl/jk_bank_controller_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// jk_bank_controller_pkg : opcodes and FSM state encoding for the JK bank
// Revision: 1.0
// ---------------------------------------------------------------------------
package jk_bank_controller_pkg;

   localparam logic [2:0] OP_NOP      = 3'd0;
   localparam logic [2:0] OP_CLEAR    = 3'd1;
   localparam logic [2:0] OP_SET      = 3'd2;
   localparam logic [2:0] OP_TOGGLE   = 3'd3;
   localparam logic [2:0] OP_LOAD     = 3'd4;
   localparam logic [2:0] OP_COUNT_UP = 3'd5;
   localparam logic [2:0] OP_COUNT_DN = 3'd6;
   localparam logic [2:0] OP_RSVD     = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_APPLY = 2'd1,
      ST_COUNT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/jk_bank_controller_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// jk_bank_controller_if : command handshake and bank observation signals
// Revision: 1.0
// ---------------------------------------------------------------------------
interface jk_bank_controller_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
);
   logic             Cmd_valid;
   logic             Cmd_ready;
   logic [2:0]       Cmd_op;
   logic [WIDTH-1:0] Cmd_data;
   logic [CNT_W-1:0] Cmd_len;
   logic [WIDTH-1:0] Q;
   logic [WIDTH-1:0] J_bus;
   logic [WIDTH-1:0] K_bus;
   logic             Busy;
   logic             Done;

   modport master (
      output Cmd_valid, Cmd_op, Cmd_data, Cmd_len,
      input  Cmd_ready, Q, J_bus, K_bus, Busy, Done
   );

   modport slave (
      input  Cmd_valid, Cmd_op, Cmd_data, Cmd_len,
      output Cmd_ready, Q, J_bus, K_bus, Busy, Done
   );
endinterface
`default_nettype wire

// File: rtl/jk_bank_controller_jk_cell.sv
`default_nettype none
// ---------------------------------------------------------------------------
// jk_cell : single JK flip-flop, synchronous active-low reset
// Revision: 1.0
// ---------------------------------------------------------------------------
module jk_cell (
   input  wire logic Clk,
   input  wire logic Reset,
   input  wire logic J,
   input  wire logic K,
   output logic      Q,
   output logic      Q_bar
);

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         Q <= 1'b0;
      end else begin
         case ({J, K})
            2'b01:   Q <= 1'b0;
            2'b10:   Q <= 1'b1;
            2'b11:   Q <= ~Q;
            default: Q <= Q;
         endcase
      end
   end

   assign Q_bar = ~Q;

endmodule
`default_nettype wire

// File: rtl/jk_bank_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// jk_bank_controller : command sequencer driving the J/K inputs of a JK bank
// Revision: 1.0
// ---------------------------------------------------------------------------
module jk_bank_controller
   import jk_bank_controller_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  wire logic      Clk,
   input  wire logic      Reset,
   jk_bank_controller_if.slave bus
);

   state_t           r_state;
   logic [2:0]       r_op;
   logic [WIDTH-1:0] r_data;
   logic [CNT_W-1:0] r_cnt;
   logic             r_done;

   logic [WIDTH-1:0] w_q;
   logic [WIDTH-1:0] w_q_bar;
   logic [WIDTH-1:0] w_t_up;
   logic [WIDTH-1:0] w_t_dn;
   logic [WIDTH-1:0] w_j;
   logic [WIDTH-1:0] w_k;

   // Bit i toggles when every lower bit is 1 (up) or every lower bit is 0 (down)
   for (genvar i = 0; i < WIDTH; i++) begin : g_tog
      if (i == 0) begin : g_lsb
         assign w_t_up[i] = 1'b1;
         assign w_t_dn[i] = 1'b1;
      end else begin : g_upper
         assign w_t_up[i] = &w_q[i-1:0];
         assign w_t_dn[i] = &w_q_bar[i-1:0];
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      jk_cell u_cell (
         .Clk   (Clk),
         .Reset (Reset),
         .J     (w_j[i]),
         .K     (w_k[i]),
         .Q     (w_q[i]),
         .Q_bar (w_q_bar[i])
      );
   end

   always_comb begin
      w_j = '0;
      w_k = '0;
      case (r_state)
         ST_APPLY: begin
            case (r_op)
               OP_CLEAR:  w_k = r_data;
               OP_SET:    w_j = r_data;
               OP_TOGGLE: begin
                  w_j = r_data;
                  w_k = r_data;
               end
               OP_LOAD: begin
                  w_j = r_data;
                  w_k = ~r_data;
               end
               default: ;
            endcase
         end
         ST_COUNT: begin
            w_j = (r_op == OP_COUNT_DN) ? w_t_dn : w_t_up;
            w_k = (r_op == OP_COUNT_DN) ? w_t_dn : w_t_up;
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_state <= ST_IDLE;
         r_op    <= OP_NOP;
         r_data  <= '0;
         r_cnt   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.Cmd_valid) begin
                  r_op   <= bus.Cmd_op;
                  r_data <= bus.Cmd_data;
                  r_cnt  <= bus.Cmd_len;
                  case (bus.Cmd_op)
                     OP_CLEAR, OP_SET, OP_TOGGLE, OP_LOAD: r_state <= ST_APPLY;
                     OP_COUNT_UP, OP_COUNT_DN: begin
                        if (bus.Cmd_len != '0) begin
                           r_state <= ST_COUNT;
                        end else begin
                           r_state <= ST_DONE;
                           r_done  <= 1'b1;
                        end
                     end
                     OP_NOP, OP_RSVD: begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                     end
                     default: r_state <= ST_IDLE;
                  endcase
               end
            end
            ST_APPLY: begin
               r_state <= ST_DONE;
               r_done  <= 1'b1;
            end
            ST_COUNT: begin
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end
            end
            ST_DONE:  r_state <= ST_IDLE;
            default:  r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.Cmd_ready = (r_state == ST_IDLE);
   assign bus.Busy      = (r_state != ST_IDLE);
   assign bus.Done      = r_done;
   assign bus.Q         = w_q;
   assign bus.J_bus     = w_j;
   assign bus.K_bus     = w_k;

endmodule
`default_nettype wire
